lfsr_rand_gen: RTL and testbench

Parametrised pseudo-random word generator for the RSA datapath. It is the next generation of the 16-bit seedable LFSR.
- Generic LFSR width; output word a multiple of the LFSR width, assembled over several cycles.
- Valid/ready output handshake, zero-seed lockup protection, optional prime-candidate shaping.
- Feeds the prime-candidate / nonce logic upstream of the modexp core.

---
 rtl/lfsr_rand_gen_pkg.sv | 27 ++
 rtl/lfsr_rand_gen_step_n.sv | 20 ++
 rtl/lfsr_rand_gen.sv | 138 +++++++++++++
 tb/tb_lfsr_rand_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_rand_gen_pkg.sv
// Shared types and per-width constants for the LFSR random word generator.
package lfsr_pkg;

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  // A zero seed would lock the LFSR, so it is replaced by this value on load.
  localparam int ZERO_SEED_SUB = 1;

  function automatic logic [63:0] taps(input int width);
    case (width)
      16:      taps = 64'h0000_0000_0000_B400;
      32:      taps = 64'h0000_0000_8020_0003;
      64:      taps = 64'hD800_0000_0000_0000;
      default: taps = '0;
    endcase
  endfunction

  function automatic logic [63:0] default_seed(input int width);
    case (width)
      16:      default_seed = 64'h0000_0000_0000_ACE1;
      32:      default_seed = 64'h0000_0000_ACE1_ACE1;
      64:      default_seed = 64'hACE1_ACE1_ACE1_ACE1;
      default: default_seed = 64'h1;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_rand_gen_step_n.sv
// Combinational advance of a shift-left Fibonacci LFSR by WIDTH single steps.
module lfsr_step_n #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = '1
) (
  input  logic [WIDTH-1:0] state_in,
  output logic [WIDTH-1:0] state_out
);

  logic [WIDTH-1:0] s;

  always_comb begin
    s = state_in;
    for (int i = 0; i < WIDTH; i++) begin
      s = {s[WIDTH-2:0], ^(s & TAPS)};
    end
    state_out = s;
  end

endmodule

// File: rtl/lfsr_rand_gen.sv
// Seedable LFSR word generator with valid/ready output and zero-seed guard.
// Optional LFSR_PRIME_CAND_EN forces the MSB and LSB of each delivered word to 1.
module lfsr_rand_gen
  import lfsr_pkg::*;
#(
  parameter int LFSR_WIDTH = 16,
  parameter int OUT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LFSR_WIDTH-1:0] seed,
  input  logic                  seed_load,
  input  logic                  start,
  output logic [OUT_WIDTH-1:0]  rand_out,
  output logic                  valid,
  input  logic                  ready,
  output logic                  busy
);

  localparam int NCHUNK = OUT_WIDTH / LFSR_WIDTH;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [63:0] TAPS_ALL = taps(LFSR_WIDTH);
  localparam logic [63:0] SEED_ALL = default_seed(LFSR_WIDTH);
  localparam logic [LFSR_WIDTH-1:0] TAPS     = TAPS_ALL[LFSR_WIDTH-1:0];
  localparam logic [LFSR_WIDTH-1:0] DEF_SEED = SEED_ALL[LFSR_WIDTH-1:0];

  if (!(LFSR_WIDTH == 16 || LFSR_WIDTH == 32 || LFSR_WIDTH == 64)) begin : g_bad_width
    $error("lfsr_rand_gen: LFSR_WIDTH must be 16, 32 or 64");
  end
  if ((OUT_WIDTH % LFSR_WIDTH) != 0 || OUT_WIDTH < LFSR_WIDTH) begin : g_bad_out
    $error("lfsr_rand_gen: OUT_WIDTH must be a multiple of LFSR_WIDTH");
  end

  state_t                 state_q, state_d;
  logic [LFSR_WIDTH-1:0]  lfsr_q, lfsr_d, lfsr_next;
  logic [OUT_WIDTH-1:0]   acc_q, acc_d, acc_shift, word;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]   rand_out_q, rand_out_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;

  lfsr_step_n #(.WIDTH(LFSR_WIDTH), .TAPS(TAPS)) u_step (
    .state_in  (lfsr_q),
    .state_out (lfsr_next)
  );

  // First chunk generated ends up in the MSBs after NCHUNK shifts.
  if (NCHUNK == 1) begin : g_one
    assign acc_shift = lfsr_next;
  end else begin : g_multi
    assign acc_shift = {acc_q[OUT_WIDTH-LFSR_WIDTH-1:0], lfsr_next};
  end

`ifdef LFSR_PRIME_CAND_EN
  assign word = {1'b1, acc_shift[OUT_WIDTH-2:1], 1'b1};
`else
  assign word = acc_shift;
`endif

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    rand_out_d = rand_out_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    if (seed_load) begin
      lfsr_d     = (seed == '0) ? LFSR_WIDTH'(ZERO_SEED_SUB) : seed;
      state_d    = IDLE;
      cnt_d      = '0;
      acc_d      = '0;
      rand_out_d = '0;
      valid_d    = 1'b0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = FILL;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
        end
        FILL: begin
          lfsr_d = lfsr_next;
          acc_d  = acc_shift;
          if (cnt_q == CNT_W'(NCHUNK - 1)) begin
            state_d    = HOLD;
            rand_out_d = word;
            valid_d    = 1'b1;
            busy_d     = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (ready) begin
            valid_d = 1'b0;
            if (start) begin
              state_d = FILL;
              cnt_d   = '0;
              busy_d  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lfsr_q     <= DEF_SEED;
      acc_q      <= '0;
      cnt_q      <= '0;
      rand_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      rand_out_q <= rand_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign rand_out = rand_out_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen: a 16/16 and a 16/64 instance sharing clk and rst.
module tb_lfsr_rand_gen;

`ifdef LFSR_PRIME_CAND_EN
  localparam bit PRIME = 1'b1;
`else
  localparam bit PRIME = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [15:0] seed_a = '0;
  logic        seed_load_a = 1'b0, start_a = 1'b0, ready_a = 1'b0;
  logic [15:0] rand_a;
  logic        valid_a, busy_a;

  logic [15:0] seed_b = '0;
  logic        seed_load_b = 1'b0, start_b = 1'b0, ready_b = 1'b0;
  logic [63:0] rand_b;
  logic        valid_b, busy_b;

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] exp_w;
  logic [15:0] st;

  always #5 clk = ~clk;

  lfsr_rand_gen #(.LFSR_WIDTH(16), .OUT_WIDTH(16)) u_dut_a (
    .clk(clk), .rst(rst), .seed(seed_a), .seed_load(seed_load_a), .start(start_a),
    .rand_out(rand_a), .valid(valid_a), .ready(ready_a), .busy(busy_a)
  );

  lfsr_rand_gen #(.LFSR_WIDTH(16), .OUT_WIDTH(64)) u_dut_b (
    .clk(clk), .rst(rst), .seed(seed_b), .seed_load(seed_load_b), .start(start_b),
    .rand_out(rand_b), .valid(valid_b), .ready(ready_b), .busy(busy_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: 16 single steps with taps 15,13,12,10.
  function automatic logic [15:0] chunk16(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < 16; i++) t = {t[14:0], t[15] ^ t[13] ^ t[12] ^ t[10]};
    return t;
  endfunction

  function automatic logic [63:0] gen64(input logic [15:0] s, output logic [15:0] s_end);
    logic [15:0] c1, c2, c3, c4;
    c1 = chunk16(s);
    c2 = chunk16(c1);
    c3 = chunk16(c2);
    c4 = chunk16(c3);
    s_end = c4;
    return {c1, c2, c3, c4};
  endfunction

  function automatic logic [63:0] shape16(input logic [15:0] w);
    return PRIME ? 64'(w | 16'h8001) : 64'(w);
  endfunction

  function automatic logic [63:0] shape64(input logic [63:0] w);
    return PRIME ? (w | 64'h8000_0000_0000_0001) : w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    check_eq("rst_valid_a", 64'(valid_a), 64'd0);
    check_eq("rst_rand_a",  64'(rand_a),  64'd0);
    check_eq("rst_busy_a",  64'(busy_a),  64'd0);
    check_eq("rst_valid_b", 64'(valid_b), 64'd0);
    check_eq("rst_rand_b",  rand_b,       64'd0);
    check_eq("rst_busy_b",  64'(busy_b),  64'd0);
    rst = 1'b1;
    tick();

    // 16/16 from seed 1: one-cycle latency, hand-derived 16'h002D
    seed_a = 16'h0001; seed_load_a = 1'b1;
    tick();
    seed_load_a = 1'b0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check_eq("t1_busy", 64'(busy_a), 64'd1);
    check_eq("t1_nvalid", 64'(valid_a), 64'd0);
    tick();
    check_eq("t1_valid", 64'(valid_a), 64'd1);
    check_eq("t1_word", 64'(rand_a), shape16(16'h002D));
    check_eq("t1_busy_lo", 64'(busy_a), 64'd0);
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    check_eq("t1_hs_drop", 64'(valid_a), 64'd0);

    // zero seed is replaced by 1
    seed_a = 16'h0000; seed_load_a = 1'b1;
    tick();
    seed_load_a = 1'b0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    check_eq("t2_valid", 64'(valid_a), 64'd1);
    check_eq("t2_word", 64'(rand_a), shape16(16'h002D));
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;

    // seed_load together with start: load wins
    seed_a = 16'h0001; seed_load_a = 1'b1; start_a = 1'b1;
    tick();
    seed_load_a = 1'b0; start_a = 1'b0;
    check_eq("ld_start_busy", 64'(busy_a), 64'd0);
    tick();
    check_eq("ld_start_valid", 64'(valid_a), 64'd0);

    // 16/64: four-cycle latency and chunk ordering
    seed_b = 16'h0001; seed_load_b = 1'b1;
    tick();
    seed_load_b = 1'b0; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      check_eq("t3_early_valid", 64'(valid_b), 64'd0);
      tick();
    end
    check_eq("t3_early_valid", 64'(valid_b), 64'd0);
    tick();
    exp_w = shape64(gen64(16'h0001, st));
    check_eq("t3_valid", 64'(valid_b), 64'd1);
    check_eq("t3_top_chunk", 64'(rand_b[63:48]), PRIME ? 64'h802D : 64'h002D);
    check_eq("t3_word", rand_b, exp_w);

    // backpressure, with start ignored while held
    start_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("t4_hold_valid", 64'(valid_b), 64'd1);
      check_eq("t4_hold_word", rand_b, exp_w);
    end
    ready_b = 1'b1;
    tick();
    ready_b = 1'b0; start_b = 1'b0;
    check_eq("t4_hs_valid", 64'(valid_b), 64'd0);
    check_eq("t4_b2b_busy", 64'(busy_b), 64'd1);
    tick();
    tick();
    tick();
    check_eq("t4_b2b_early", 64'(valid_b), 64'd0);
    tick();
    exp_w = shape64(gen64(st, st));
    check_eq("t4_b2b_valid", 64'(valid_b), 64'd1);
    check_eq("t4_b2b_word", rand_b, exp_w);
    ready_b = 1'b1;
    tick();
    ready_b = 1'b0;

    // seed_load while cnt==2 discards the partial word
    seed_b = 16'h1234; seed_load_b = 1'b1;
    tick();
    seed_load_b = 1'b0; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    tick();
    seed_b = 16'hBEEF; seed_load_b = 1'b1;
    tick();
    seed_load_b = 1'b0;
    check_eq("t5_busy", 64'(busy_b), 64'd0);
    check_eq("t5_valid", 64'(valid_b), 64'd0);
    tick();
    tick();
    check_eq("t5_idle_valid", 64'(valid_b), 64'd0);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check_eq("t5_valid_new", 64'(valid_b), 64'd1);
    check_eq("t5_word_new", rand_b, shape64(gen64(16'hBEEF, st)));

    // async reset while holding, observed before any clock edge
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6_valid", 64'(valid_b), 64'd0);
    check_eq("t6_rand", rand_b, 64'd0);
    check_eq("t6_busy", 64'(busy_b), 64'd0);
    tick();
    rst = 1'b1;
    start_a = 1'b1; start_b = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
    tick();
    check_eq("t6_a_valid", 64'(valid_a), 64'd1);
    check_eq("t6_a_word", 64'(rand_a), shape16(chunk16(16'hACE1)));
    tick();
    tick();
    tick();
    check_eq("t6_b_valid", 64'(valid_b), 64'd1);
    check_eq("t6_b_word", rand_b, shape64(gen64(16'hACE1, st)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
